// File: rtl/elm_ser_scheduler.sv
// Round-robin scheduler that shares one 256-to-16 serializer among NUM_REQ result producers.
// Optional watchdog is built when ELM_SER_SCHED_WDOG_EN is defined; otherwise wdog_err is tied low.

module elm_ser_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 256,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [DATA_W-1:0]         ser_parallel_data,
    output logic                      ser_rx,
    input  logic [4:0]                ser_count,
    input  logic                      ser_tx,
    output logic                      busy,
    output logic [ID_W-1:0]           cur_id,
    output logic [4:0]                word_cnt,
    output logic                      frame_done,
    output logic                      wdog_err
);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   last;
    logic [ID_W-1:0]   winner;
    logic              found;
    logic              last_word;
    logic              wdog_trip;
    logic [DATA_W-1:0] slice [NUM_REQ];

    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign slice[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    assign last_word = ser_tx && (ser_count == 5'd0);
    assign busy      = (state != IDLE);

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int pos;
            pos = int'(last) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (!found && req[pos[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = pos[ID_W-1:0];
            end
        end
    end

`ifdef ELM_SER_SCHED_WDOG_EN
    logic [5:0] wdog_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= 6'd0;
            wdog_err <= 1'b0;
        end else begin
            if (state == LOAD)
                wdog_cnt <= 6'd0;
            else if (state == STREAM || state == DRAIN)
                wdog_cnt <= wdog_cnt + 6'd1;
            if (wdog_trip)
                wdog_err <= 1'b1;
        end
    end

    // Trips on the edge where the counter would reach 40.
    assign wdog_trip = (state == STREAM || state == DRAIN) && (wdog_cnt == 6'd39);
`else
    assign wdog_trip = 1'b0;
    assign wdog_err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found)     state_next = LOAD;
            LOAD:                   state_next = STREAM;
            STREAM:  if (last_word) state_next = DRAIN;
            DRAIN:   if (!ser_tx)   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
        if (wdog_trip)
            state_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant             <= '0;
            ser_parallel_data <= '0;
            ser_rx            <= 1'b0;
            cur_id            <= '0;
            word_cnt          <= 5'd0;
            frame_done        <= 1'b0;
            last              <= ID_W'(NUM_REQ - 1);
        end else begin
            grant      <= '0;
            ser_rx     <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        ser_parallel_data <= slice[winner];
                        ser_rx            <= 1'b1;
                        grant[winner]     <= 1'b1;
                        cur_id            <= winner;
                        last              <= winner;
                        word_cnt          <= 5'd0;
                    end
                end
                STREAM: begin
                    // A watchdog abort must not look like a completed frame.
                    if (!wdog_trip) begin
                        if (ser_tx && word_cnt != 5'd16)
                            word_cnt <= word_cnt + 5'd1;
                        if (last_word)
                            frame_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_elm_ser_scheduler.sv
// Bench for elm_ser_scheduler: behavioural 256-to-16 serializer plus a round-robin reference model.
// Define ELM_SER_SCHED_WDOG_EN for both bench and design to exercise the watchdog.

module tb_elm_ser_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 256;
    localparam int ID_W    = 2;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [DATA_W-1:0]         ser_parallel_data;
    logic                      ser_rx;
    logic [4:0]                ser_count;
    logic                      ser_tx;
    logic                      busy;
    logic [ID_W-1:0]           cur_id;
    logic [4:0]                word_cnt;
    logic                      frame_done;
    logic                      wdog_err;

    logic [255:0] ser_sh;
    logic [15:0]  ser_word;
    bit           ser_stall = 1'b0;
    int           rx_viol   = 0;
    int           cyc       = 0;

    int n_cmp;
    int n_err;
    int last_ref;
    bit drop_on_grant;
    bit scramble;

    typedef struct {
        logic [3:0]   g;
        logic [1:0]   id;
        int           t_grant;
        int           t_done;
        int           t_idle;
        int           rx_cnt;
        int           nwords;
        int           fd_cnt;
        logic [4:0]   wc;
        logic [255:0] data;
        bit           timeout;
    } obs_t;

    elm_ser_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant),
        .ser_parallel_data(ser_parallel_data), .ser_rx(ser_rx), .ser_count(ser_count),
        .ser_tx(ser_tx), .busy(busy), .cur_id(cur_id), .word_cnt(word_cnt),
        .frame_done(frame_done), .wdog_err(wdog_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Serializer: load on rx, then one MSB-first word per cycle while count counts down to 0.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ser_sh    <= '0;
            ser_word  <= '0;
            ser_count <= 5'd0;
            ser_tx    <= 1'b0;
        end else begin
            if (ser_rx && ser_tx) rx_viol <= rx_viol + 1;
            if (ser_rx) begin
                ser_sh    <= ser_parallel_data;
                ser_count <= 5'd16;
                ser_tx    <= 1'b0;
            end else if (ser_count != 5'd0 && !ser_stall) begin
                ser_word  <= ser_sh[255:240];
                ser_sh    <= {ser_sh[239:0], 16'h0000};
                ser_count <= ser_count - 5'd1;
                ser_tx    <= 1'b1;
            end else begin
                ser_tx    <= 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 500000");
        $fatal(1, "[TB] global timeout");
    end

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
        return r;
    endfunction

    // Round-robin reference: first asserted requester after the previous winner.
    function automatic int pick(input logic [3:0] r, input int prev);
        int idx;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (prev + k) % NUM_REQ;
            if (r[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_ref = NUM_REQ - 1;
    endtask

    // Observation only: waits for a grant and records the whole frame as seen at negedges.
    task automatic observe_frame(output obs_t o);
        int n;
        o = '{default: 0};
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == '0 && n < 200);
        if (grant == '0) begin
            o.timeout = 1'b1;
            return;
        end
        o.g       = grant;
        o.id      = cur_id;
        o.t_grant = cyc;
        o.rx_cnt  = int'(ser_rx);
        if (scramble)
            for (int i = 0; i < NUM_REQ; i++)
                if (o.g[i]) req_data[i*256 +: 256] = ~req_data[i*256 +: 256];
        if (drop_on_grant) req = req & ~o.g;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            o.rx_cnt += int'(ser_rx);
            if (ser_tx) begin
                o.data = {o.data[239:0], ser_word};
                o.nwords++;
            end
            if (frame_done) begin
                o.fd_cnt++;
                o.t_done = cyc;
                o.wc     = word_cnt;
            end
            if (!busy) begin
                o.t_idle = cyc;
                break;
            end
            if (n >= 60) begin
                o.timeout = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*256 +: 256] = rand256();
        repeat (2) @(negedge clk);
        n_cmp++; if (grant !== 4'b0) begin n_err++; $display("[TB] FAIL rst_grant: got %b expected 0", grant); end
        n_cmp++; if (ser_rx !== 1'b0) begin n_err++; $display("[TB] FAIL rst_ser_rx: got %b expected 0", ser_rx); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        n_cmp++; if (cur_id !== 2'd0) begin n_err++; $display("[TB] FAIL rst_cur_id: got %0d expected 0", cur_id); end
        n_cmp++; if (word_cnt !== 5'd0) begin n_err++; $display("[TB] FAIL rst_word_cnt: got %0d expected 0", word_cnt); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("[TB] FAIL rst_frame_done: got %b expected 0", frame_done); end
        n_cmp++; if (wdog_err !== 1'b0) begin n_err++; $display("[TB] FAIL rst_wdog_err: got %b expected 0", wdog_err); end
        n_cmp++; if (ser_parallel_data !== 256'd0) begin n_err++; $display("[TB] FAIL rst_ser_data: got %h expected 0", ser_parallel_data); end
        rst = 1'b0;
        last_ref = NUM_REQ - 1;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL idle_no_req_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single_frame();
        obs_t o;
        logic [255:0] d0;
        d0 = 256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000a_000b_000c_000d_000e_000f_0010;
        req_data[255:0] = d0;
        drop_on_grant = 1'b1;
        req = 4'b0001;
        observe_frame(o);
        last_ref = 0;
        n_cmp++; if (o.timeout !== 1'b0) begin n_err++; $display("[TB] FAIL single_timeout: got %b expected 0", o.timeout); end
        n_cmp++; if (o.g !== 4'b0001) begin n_err++; $display("[TB] FAIL single_grant: got %b expected 0001", o.g); end
        n_cmp++; if (o.id !== 2'd0) begin n_err++; $display("[TB] FAIL single_cur_id: got %0d expected 0", o.id); end
        n_cmp++; if (o.rx_cnt !== 1) begin n_err++; $display("[TB] FAIL single_rx_cycles: got %0d expected 1", o.rx_cnt); end
        n_cmp++; if (o.nwords !== 16) begin n_err++; $display("[TB] FAIL single_words: got %0d expected 16", o.nwords); end
        n_cmp++; if (o.data !== d0) begin n_err++; $display("[TB] FAIL single_stream: got %h expected %h", o.data, d0); end
        n_cmp++; if (o.wc !== 5'd16) begin n_err++; $display("[TB] FAIL single_word_cnt: got %0d expected 16", o.wc); end
        n_cmp++; if (o.fd_cnt !== 1) begin n_err++; $display("[TB] FAIL single_fd_count: got %0d expected 1", o.fd_cnt); end
        n_cmp++; if (o.t_done - o.t_grant !== 18) begin n_err++; $display("[TB] FAIL single_done_time: got T+%0d expected T+18", o.t_done - o.t_grant); end
        n_cmp++; if (o.t_idle - o.t_grant !== 19) begin n_err++; $display("[TB] FAIL single_idle_time: got T+%0d expected T+19", o.t_idle - o.t_grant); end
    endtask

    task automatic test_round_robin();
        obs_t o;
        int exp;
        int prev_t;
        logic [3:0] eg;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) req_data[i*256 +: 256] = rand256();
        drop_on_grant = 1'b0;
        req = 4'b1111;
        prev_t = 0;
        for (int f = 0; f < 5; f++) begin
            exp = pick(req, last_ref);
            eg  = 4'b0001 << exp;
            observe_frame(o);
            n_cmp++; if (o.g !== eg) begin n_err++; $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", f, o.g, eg); end
            n_cmp++; if (o.data !== req_data[exp*256 +: 256]) begin n_err++; $display("[TB] FAIL rr_data[%0d]: got %h expected %h", f, o.data, req_data[exp*256 +: 256]); end
            if (f > 0) begin
                n_cmp++; if (o.t_grant - prev_t !== 20) begin n_err++; $display("[TB] FAIL rr_period[%0d]: got %0d expected 20", f, o.t_grant - prev_t); end
            end
            prev_t   = o.t_grant;
            last_ref = exp;
        end
        req = '0;
        drop_on_grant = 1'b1;
    endtask

    task automatic test_skip_fairness();
        obs_t o;
        logic [3:0] eg [3];
        logic [1:0] ei [3];
        eg = '{4'b0001, 4'b0100, 4'b0001};
        ei = '{2'd0, 2'd2, 2'd0};
        apply_reset();
        drop_on_grant = 1'b0;
        req = 4'b0101;
        for (int f = 0; f < 3; f++) begin
            observe_frame(o);
            n_cmp++; if (o.g !== eg[f]) begin n_err++; $display("[TB] FAIL skip_grant[%0d]: got %b expected %b", f, o.g, eg[f]); end
            n_cmp++; if (o.id !== ei[f]) begin n_err++; $display("[TB] FAIL skip_cur_id[%0d]: got %0d expected %0d", f, o.id, ei[f]); end
        end
        req = '0;
        drop_on_grant = 1'b1;
        last_ref = 0;
    endtask

    task automatic test_data_hold();
        obs_t o;
        logic [255:0] cap;
        cap = rand256();
        req_data[1*256 +: 256] = cap;
        scramble = 1'b1;
        req = 4'b0010;
        observe_frame(o);
        scramble = 1'b0;
        last_ref = 1;
        n_cmp++; if (o.g !== 4'b0010) begin n_err++; $display("[TB] FAIL hold_grant: got %b expected 0010", o.g); end
        n_cmp++; if (o.data !== cap) begin n_err++; $display("[TB] FAIL hold_data: got %h expected %h", o.data, cap); end
    endtask

    task automatic test_random();
        obs_t o;
        logic [3:0] keep;
        logic [3:0] nb;
        logic [3:0] eg;
        int exp;
        int gap;
        for (int f = 0; f < 12; f++) begin
            keep = req & 4'($urandom_range(0, 15));
            nb   = 4'($urandom_range(1, 15));
            req  = '0;
            gap  = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) req_data[i*256 +: 256] = rand256();
            req = keep | nb;
            exp = pick(req, last_ref);
            eg  = 4'b0001 << exp;
            observe_frame(o);
            n_cmp++; if (o.g !== eg) begin n_err++; $display("[TB] FAIL rand_grant[%0d]: got %b expected %b", f, o.g, eg); end
            n_cmp++; if (o.id !== 2'(exp)) begin n_err++; $display("[TB] FAIL rand_cur_id[%0d]: got %0d expected %0d", f, o.id, exp); end
            n_cmp++; if (o.data !== req_data[exp*256 +: 256]) begin n_err++; $display("[TB] FAIL rand_data[%0d]: got %h expected %h", f, o.data, req_data[exp*256 +: 256]); end
            n_cmp++; if (o.t_done - o.t_grant !== 18) begin n_err++; $display("[TB] FAIL rand_done_time[%0d]: got T+%0d expected T+18", f, o.t_done - o.t_grant); end
            n_cmp++; if (o.t_idle - o.t_grant !== 19) begin n_err++; $display("[TB] FAIL rand_idle_time[%0d]: got T+%0d expected T+19", f, o.t_idle - o.t_grant); end
            last_ref = exp;
        end
        req = '0;
        n_cmp++; if (rx_viol !== 0) begin n_err++; $display("[TB] FAIL rx_during_tx: got %0d expected 0", rx_viol); end
    endtask

    task automatic test_reset_mid_frame();
        obs_t o;
        int n;
        int fd;
        req = 4'b0010;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == '0 && n < 50);
        n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("[TB] FAIL mid_first_grant: got %b expected 0010", grant); end
        req = '0;
        repeat (8) @(negedge clk);
        n_cmp++; if (word_cnt !== 5'd6) begin n_err++; $display("[TB] FAIL mid_word_cnt: got %0d expected 6", word_cnt); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL mid_busy: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({grant, ser_rx, busy, cur_id, word_cnt, frame_done, wdog_err} !== 15'd0) begin n_err++; $display("[TB] FAIL mid_rst_outputs: got %h expected 0", {grant, ser_rx, busy, cur_id, word_cnt, frame_done, wdog_err}); end
        n_cmp++; if (ser_parallel_data !== 256'd0) begin n_err++; $display("[TB] FAIL mid_rst_data: got %h expected 0", ser_parallel_data); end
        req = 4'b1111;
        fd = 0;
        repeat (3) begin
            @(negedge clk);
            fd += int'(frame_done);
        end
        rst = 1'b0;
        last_ref = NUM_REQ - 1;
        observe_frame(o);
        req = '0;
        last_ref = 0;
        n_cmp++; if (fd !== 0) begin n_err++; $display("[TB] FAIL mid_no_frame_done: got %0d expected 0", fd); end
        n_cmp++; if (o.g !== 4'b0001) begin n_err++; $display("[TB] FAIL mid_next_grant: got %b expected 0001", o.g); end
        n_cmp++; if (o.fd_cnt !== 1) begin n_err++; $display("[TB] FAIL mid_next_frame: got %0d expected 1", o.fd_cnt); end
    endtask

    task automatic test_watchdog();
        int n;
        int t0;
        int tw;
        int fd;
        logic busy_at;
        apply_reset();
        ser_stall = 1'b1;
        req = 4'b0001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == '0 && n < 50);
        n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("[TB] FAIL wd_grant: got %b expected 0001", grant); end
        req = '0;
        t0 = cyc;
        tw = -1;
        fd = 0;
        busy_at = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            fd += int'(frame_done);
            if (wdog_err === 1'b1 && tw < 0) begin
                tw = cyc - t0;
                busy_at = busy;
            end
        end
        n_cmp++; if (fd !== 0) begin n_err++; $display("[TB] FAIL wd_frame_done: got %0d expected 0", fd); end
`ifdef ELM_SER_SCHED_WDOG_EN
        n_cmp++; if (tw !== 41) begin n_err++; $display("[TB] FAIL wd_trip_time: got T+%0d expected T+41", tw); end
        n_cmp++; if (busy_at !== 1'b0) begin n_err++; $display("[TB] FAIL wd_busy: got %b expected 0", busy_at); end
        n_cmp++; if (wdog_err !== 1'b1) begin n_err++; $display("[TB] FAIL wd_sticky: got %b expected 1", wdog_err); end
`else
        n_cmp++; if (tw !== -1) begin n_err++; $display("[TB] FAIL wd_absent_err: got %0d expected -1", tw); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL wd_absent_busy: got %b expected 1", busy); end
`endif
        apply_reset();
        ser_stall = 1'b0;
        n_cmp++; if (wdog_err !== 1'b0) begin n_err++; $display("[TB] FAIL wd_rst_clear: got %b expected 0", wdog_err); end
    endtask

    initial begin
        rst = 1'b0;
        req = '0;
        req_data = '0;
        n_cmp = 0;
        n_err = 0;
        last_ref = NUM_REQ - 1;
        drop_on_grant = 1'b1;
        scramble = 1'b0;
        #1;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_skip_fairness();
        test_data_hold();
        test_random();
        test_reset_mid_frame();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/elm_ser_scheduler.md
Name: elm_ser_scheduler

Overview:
- Round-robin scheduler that shares the single 256-bit-to-16-bit serializer between NUM_REQ result producers in the ELM engine, e.g. hidden-layer and output-layer result buffers.
- Arbitrates among pending producers, captures the winner's 256-bit vector, and pulses the serializer load strobe (ser_rx).
- Tracks the 16-word burst through the serializer's count and tx outputs, then reports frame completion.
- Sits between the result buffers and the serializer instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 256, parallel vector width; fixed to the serializer input width.
- ID_W, 2, width of cur_id; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester "vector ready"; held high until that requester's grant bit pulses.
- req_data  in  NUM_REQ*DATA_W  packed vectors; requester i occupies bits [i*DATA_W +: DATA_W].
- grant  out  NUM_REQ  one-hot, one-cycle pulse: the winner's data has been captured.
- ser_parallel_data  out  DATA_W  registered vector driven to the serializer.
- ser_rx  out  1  one-cycle load strobe to the serializer.
- ser_count  in  5  serializer remaining-word count.
- ser_tx  in  1  serializer word-valid.
- busy  out  1  high in every state except IDLE.
- cur_id  out  ID_W  index of the requester being streamed.
- word_cnt  out  5  words emitted in the current frame, 0..16.
- frame_done  out  1  one-cycle pulse when the 16th word has been emitted.
- wdog_err  out  1  sticky watchdog error (see Optional Feature).

Behaviour:
- Reset (async, rst=1) forces:
  - all outputs to 0, including ser_parallel_data, grant, ser_rx, busy, cur_id, word_cnt, frame_done and wdog_err;
  - state to IDLE;
  - round-robin pointer last to NUM_REQ-1, so requester 0 has first priority.
- Reset mid-frame abandons the frame. No frame_done is issued, and the serializer is not re-strobed.
- FSM states: IDLE, LOAD, STREAM, DRAIN.
- IDLE:
  - If |req at a clock edge, select the first asserted index searching last+1, last+2, … (mod NUM_REQ).
  - At that edge, register the winner's slice into ser_parallel_data, set ser_rx<=1, grant<=onehot(winner), cur_id<=winner, last<=winner, word_cnt<=0, busy<=1, and go to LOAD.
  - If no request is pending, stay in IDLE.
- LOAD:
  - Lasts exactly one cycle; ser_rx and grant are high during it.
  - At the next edge the serializer loads (count=16, tx=0). The scheduler sets ser_rx<=0 and grant<=0 and goes to STREAM.
- STREAM:
  - word_cnt increments at every edge where ser_tx=1, saturating at 16.
  - At the edge where ser_tx=1 and ser_count=0 (16th word on the bus), set frame_done<=1 and go to DRAIN.
- DRAIN:
  - frame_done is high for this cycle only.
  - Wait for ser_tx=0, then go to IDLE with busy<=0.
  - ser_rx is never asserted while the serializer's tx=1.
- Timing, with the grant edge taken as T:
  - ser_rx is high from T to T+1.
  - frame_done rises at T+18.
  - IDLE is re-entered at T+19; the earliest next grant edge is T+20.
  - Back-to-back frame period is therefore 20 cycles.
- Request handling:
  - req edges arriving outside IDLE are only sampled on return to IDLE.
  - A req deasserted before it is granted is simply skipped.
  - req_data of the granted requester may change from T+1 onward; the captured copy is used.
- With a single requester continuously asserted, it wins every arbitration.
- With all requesters asserted, grant order from reset is 0,1,2,3,0,…

Optional Feature:
- Macro: ELM_SER_SCHED_WDOG_EN.
- With the macro defined:
  - A 6-bit counter clears on entry to STREAM and increments each cycle in STREAM or DRAIN.
  - If it reaches 40 before IDLE is re-entered, set wdog_err<=1 (sticky until rst), force IDLE with busy<=0, and issue no frame_done.
- Without the macro: no counter is built, and wdog_err is tied to 0.

Test Plan:
- Single frame: req=4'b0001, data0=256'h0001_0002_…_0010 → grant=0001 pulse at T, ser_rx high for one cycle, word_cnt reaches 16, frame_done at T+18, busy low at T+19; the serializer stream reads 0x0001..0x0010.
- Round-robin: req=4'b1111 held through 4 frames → grant sequence 0001,0010,0100,1000; grant edges spaced 20 cycles apart.
- Skip and fairness: req=4'b0101 → grants 0001, 0100, 0001; requester 1 is never granted; cur_id sequence 0,2,0.
- Data hold: change req_data of the granted requester at T+1 → serializer output still matches the value captured at T.
- Reset mid-frame: assert rst at T+8 → all outputs 0 immediately, no frame_done; next grant to requester 0 after rst releases.
- Watchdog (macro defined): serializer model holds ser_tx=0 after load → wdog_err=1 at 40 cycles after STREAM entry, busy=0, frame_done never pulses; without the macro, busy stays high and wdog_err=0.
